signal_patch_ctrl: RTL and testbench

Parametrised, trigger-driven patch controller inserted between a design's original signals and their consumers. Each of NUM_SIG channels is returned to the design unmodified or as a forced, inverted or held value. Overrides apply only inside a programmable activation window opened by a masked pattern match on the observed signals. It generalises the fixed single-bit tap/return patch port to a configurable, sequenced patch with a register interface.

---
 rtl/signal_patch_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_signal_patch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_patch_ctrl.sv
// signal_patch_ctrl: trigger-driven patch controller between tapped design
// signals and their consumers. Each channel is returned unmodified, forced
// to 0/1, inverted or held, but only inside an activation window. The
// window opens on a masked pattern match, after a programmable delay, and
// lasts a programmable number of cycles. A small register file configures it.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   sig_in        original signals (tap side)
//   sig_out       controlled signals returned to the design (combinational)
//   cfg_we/re     register write / read strobes
//   cfg_addr      register select (0 CTRL .. 7 STATUS)
//   cfg_wdata     write data
//   cfg_rdata     registered read data, holds until the next read
//   patch_active  high while the override window is open

// One patched channel: its mode register, its hold bit and its output mux.
module signal_patch_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig,
  input  logic       active,
  input  logic       capture,
  input  logic       mode_we,
  input  logic [2:0] mode_wdata,
  output logic [2:0] mode,
  output logic       sig_out
);
  logic hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 3'd0;
      hold <= 1'b0;
    end else begin
      if (mode_we) mode <= mode_wdata;
      if (capture) hold <= sig;
    end
  end

  // Only state and stored mode/hold feed this mux, never cfg inputs.
  always_comb begin
    sig_out = sig;
    if (active) begin
      case (mode)
        3'd1:    sig_out = 1'b0;
        3'd2:    sig_out = 1'b1;
        3'd3:    sig_out = ~sig;
        3'd4:    sig_out = hold;
        default: sig_out = sig;
      endcase
    end
  end
endmodule

module signal_patch_ctrl #(
  parameter int NUM_SIG = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SIG-1:0] sig_in,
  output logic [NUM_SIG-1:0] sig_out,
  input  logic               cfg_we,
  input  logic               cfg_re,
  input  logic [2:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               patch_active
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DELAY  = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      inf, inf_nxt;   // window opened with DURATION==0
  logic                      enter;
  logic [7:0]                act_cnt;

  logic [NUM_SIG-1:0]        trig_mask, trig_value;
  logic [CNT_W-1:0]          dly, dur;
  logic [4:0]                mode_idx;
  logic                      rearm;
  logic [NUM_SIG-1:0][2:0]   mode;
  logic [NUM_SIG-1:0]        mode_we;
  logic [31:0]               rd_mux;
  logic                      active;
  logic                      match, arm, disarm;
  logic                      unused;

  assign unused = ^cfg_wdata;

  assign arm    = cfg_we && (cfg_addr == 3'd0) && cfg_wdata[0];
  assign disarm = cfg_we && (cfg_addr == 3'd0) && cfg_wdata[1];
  assign match  = ((sig_in ^ trig_value) & trig_mask) == '0;
  assign active = (state == S_ACTIVE);
  assign patch_active = active;

  // Config registers; MODE writes are routed to the lanes via mode_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_mask  <= '0;
      trig_value <= '0;
      dly        <= '0;
      dur        <= '0;
      mode_idx   <= '0;
      rearm      <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    rearm      <= cfg_wdata[2];
        3'd1:    trig_mask  <= cfg_wdata[NUM_SIG-1:0];
        3'd2:    trig_value <= cfg_wdata[NUM_SIG-1:0];
        3'd3:    dly        <= cfg_wdata[CNT_W-1:0];
        3'd4:    dur        <= cfg_wdata[CNT_W-1:0];
        3'd5:    mode_idx   <= cfg_wdata[4:0];
        default: ;
      endcase
    end
  end

  // An out-of-range MODE_IDX selects no lane, so the write is dropped.
  always_comb begin
    mode_we = '0;
    for (int i = 0; i < NUM_SIG; i++)
      mode_we[i] = cfg_we && (cfg_addr == 3'd6) && (mode_idx == 5'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      inf     <= 1'b0;
      act_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      inf   <= inf_nxt;
      if (enter && act_cnt != 8'hFF) act_cnt <= act_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inf_nxt   = inf;
    enter     = 1'b0;
    if (disarm) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (arm) state_nxt = S_ARMED;
        S_ARMED:  if (match) begin
                    if (dly == '0) enter = 1'b1;
                    else begin
                      state_nxt = S_DELAY;
                      cnt_nxt   = dly - 1'b1;
                    end
                  end
        S_DELAY:  if (cnt == '0) enter = 1'b1;
                  else cnt_nxt = cnt - 1'b1;
        S_ACTIVE: if (!inf) begin
                    if (cnt == '0) state_nxt = rearm ? S_ARMED : S_IDLE;
                    else cnt_nxt = cnt - 1'b1;
                  end
        default:  state_nxt = S_IDLE;
      endcase
    end
    // DURATION is sampled here, at entry, so mid-window writes wait a turn.
    if (enter) begin
      state_nxt = S_ACTIVE;
      cnt_nxt   = dur - 1'b1;
      inf_nxt   = (dur == '0);
    end
  end

  for (genvar g = 0; g < NUM_SIG; g++) begin : g_lane
    signal_patch_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig        (sig_in[g]),
      .active     (active),
      .capture    (enter),
      .mode_we    (mode_we[g]),
      .mode_wdata (cfg_wdata[2:0]),
      .mode       (mode[g]),
      .sig_out    (sig_out[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      3'd0: rd_mux[2] = rearm;
      3'd1: rd_mux[NUM_SIG-1:0] = trig_mask;
      3'd2: rd_mux[NUM_SIG-1:0] = trig_value;
      3'd3: rd_mux[CNT_W-1:0] = dly;
      3'd4: rd_mux[CNT_W-1:0] = dur;
      3'd5: rd_mux[4:0] = mode_idx;
      3'd6: for (int i = 0; i < NUM_SIG; i++)
              if (mode_idx == 5'(i)) rd_mux[2:0] = mode[i];
      3'd7: begin
              rd_mux[1:0]  = state;
              rd_mux[15:8] = act_cnt;
            end
      default: ;
    endcase
  end

  // Registered read port sees pre-write values on a same-cycle read/write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cfg_rdata <= '0;
    else if (cfg_re) cfg_rdata <= rd_mux;
  end
endmodule

// File: tb/tb_signal_patch_ctrl.sv
// Testbench for signal_patch_ctrl (NUM_SIG=4, CNT_W=8). A reference model
// schedules activation windows in absolute cycle numbers and is checked
// every cycle; a vector table and directed sequences add fixed expectations.
module tb_signal_patch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sig_in, sig_out;
  logic        cfg_we, cfg_re;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        patch_active;

  signal_patch_ctrl #(.NUM_SIG(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_out(sig_out),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .patch_active(patch_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [3:0]  m_mask, m_val, m_hold;
  logic [7:0]  m_dly, m_dur;
  logic [4:0]  m_midx;
  logic        m_rearm;
  logic [2:0]  m_mode [4];
  int          m_cnt;
  bit          m_armed, m_pend, m_started, m_inf;
  int          m_ws, m_we, ncyc;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_mask = 0; m_val = 0; m_hold = 0; m_dly = 0; m_dur = 0; m_midx = 0;
    m_rearm = 0; m_cnt = 0; m_armed = 0; m_pend = 0; m_started = 0;
    m_inf = 0; m_rd = 0;
    for (int i = 0; i < 4; i++) m_mode[i] = 3'd0;
  endtask

  function automatic int m_state();
    if (m_pend) return m_started ? 3 : 2;
    return m_armed ? 1 : 0;
  endfunction

  function automatic logic [31:0] m_rdmux(input logic [2:0] a);
    logic [31:0] r = 32'd0;
    case (a)
      3'd0: r[2] = m_rearm;
      3'd1: r[3:0] = m_mask;
      3'd2: r[3:0] = m_val;
      3'd3: r[7:0] = m_dly;
      3'd4: r[7:0] = m_dur;
      3'd5: r[4:0] = m_midx;
      3'd6: if (m_midx < 5'd4) r[2:0] = m_mode[m_midx[1:0]];
      default: r = {16'd0, 8'(m_cnt), 6'd0, 2'(m_state())};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] m_out(input logic [3:0] s);
    logic [3:0] o = s;
    if (m_state() == 3)
      for (int i = 0; i < 4; i++)
        case (m_mode[i])
          3'd1: o[i] = 1'b0;
          3'd2: o[i] = 1'b1;
          3'd3: o[i] = ~s[i];
          3'd4: o[i] = m_hold[i];
          default: ;
        endcase
    return o;
  endfunction

  task automatic model_open(input logic [3:0] s);
    m_started = 1; m_we = ncyc + int'(m_dur); m_inf = (m_dur == 0);
    m_hold = s; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  // One rising edge: decisions use the pre-edge registers, writes land after.
  task automatic model_step(input logic we, input logic re, input logic [2:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    bit arm, disarm, match;
    ncyc++;
    if (re) m_rd = m_rdmux(a);
    arm    = we && a == 3'd0 && d[0];
    disarm = we && a == 3'd0 && d[1];
    match  = ((s & m_mask) == (m_val & m_mask));
    if (disarm) begin
      m_armed = 0; m_pend = 0; m_started = 0;
    end else if (m_pend && m_started) begin
      if (!m_inf && ncyc == m_we) begin
        m_pend = 0; m_started = 0; m_armed = m_rearm;
      end
    end else if (m_pend) begin
      if (ncyc == m_ws) model_open(s);
    end else if (m_armed) begin
      if (match) begin
        m_armed = 0; m_pend = 1; m_ws = ncyc + int'(m_dly);
        if (m_dly == 0) model_open(s);
      end
    end else if (arm) m_armed = 1;
    if (we)
      case (a)
        3'd0: m_rearm = d[2];
        3'd1: m_mask = d[3:0];
        3'd2: m_val = d[3:0];
        3'd3: m_dly = d[7:0];
        3'd4: m_dur = d[7:0];
        3'd5: m_midx = d[4:0];
        3'd6: if (m_midx < 5'd4) m_mode[m_midx[1:0]] = d[2:0];
        default: ;
      endcase
  endtask

  // ---------------- checking / driving ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [3:0] sig_cur;

  task automatic cycle(input logic we, input logic re, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    cfg_we = we; cfg_re = re; cfg_addr = a; cfg_wdata = d; sig_in = s;
    @(posedge clk);
    model_step(we, re, a, d, s);
    @(negedge clk);
    chk("model_sig_out", 32'(sig_out), 32'(m_out(s)));
    chk("model_patch_active", 32'(patch_active), 32'(m_state() == 3));
    chk("model_cfg_rdata", cfg_rdata, m_rd);
    cfg_we = 0; cfg_re = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, a, d, sig_cur);
  endtask
  task automatic rd(input logic [2:0] a);
    cycle(1'b0, 1'b1, a, 32'd0, sig_cur);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, sig_cur);
  endtask

  typedef struct {
    logic we; logic re; logic [2:0] addr; logic [31:0] wdata; logic [3:0] sig;
    logic [3:0] exp_out; logic exp_act; logic chk_rd; logic [31:0] exp_rd;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic re, input logic [2:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [3:0] eo, input logic ea,
                              input logic cr, input logic [31:0] er);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = d; v.sig = s;
    v.exp_out = eo; v.exp_act = ea; v.chk_rd = cr; v.exp_rd = er;
    return v;
  endfunction

  logic        we_r, re_r;
  logic [2:0]  a_r;
  logic [31:0] d_r;

  initial begin
    // Mask 1 / value 1, DELAY 2, DURATION 3, ch1 FORCE1, then a trigger.
    vq.push_back(mk(1,0,3'd1,32'd1,4'h0, 4'h0,0, 0,0));
    vq.push_back(mk(1,0,3'd2,32'd1,4'h0, 4'h0,0, 0,0));
    vq.push_back(mk(1,0,3'd3,32'd2,4'h0, 4'h0,0, 0,0));
    vq.push_back(mk(1,0,3'd4,32'd3,4'h0, 4'h0,0, 0,0));
    vq.push_back(mk(1,0,3'd5,32'd1,4'h0, 4'h0,0, 0,0));
    vq.push_back(mk(1,0,3'd6,32'd2,4'h0, 4'h0,0, 0,0));
    vq.push_back(mk(1,0,3'd0,32'd1,4'h0, 4'h0,0, 0,0));   // ARM
    vq.push_back(mk(0,0,3'd0,32'd0,4'h1, 4'h1,0, 0,0));   // match -> DELAY
    vq.push_back(mk(0,0,3'd0,32'd0,4'h1, 4'h1,0, 0,0));
    vq.push_back(mk(0,0,3'd0,32'd0,4'h1, 4'h3,1, 0,0));   // ACTIVE x3
    vq.push_back(mk(0,0,3'd0,32'd0,4'h1, 4'h3,1, 0,0));
    vq.push_back(mk(0,0,3'd0,32'd0,4'h1, 4'h3,1, 0,0));
    vq.push_back(mk(0,0,3'd0,32'd0,4'h1, 4'h1,0, 0,0));   // back to IDLE
    vq.push_back(mk(0,1,3'd7,32'd0,4'h1, 4'h1,0, 1,32'h0000_0100));
    vq.push_back(mk(0,1,3'd6,32'd0,4'h1, 4'h1,0, 1,32'd2));
    vq.push_back(mk(0,1,3'd1,32'd0,4'h1, 4'h1,0, 1,32'd1));
    vq.push_back(mk(1,0,3'd0,32'd3,4'h1, 4'h1,0, 0,0));   // ARM+DISARM
    vq.push_back(mk(0,1,3'd7,32'd0,4'h1, 4'h1,0, 1,32'h0000_0100));
    vq.push_back(mk(1,1,3'd3,32'd7,4'h1, 4'h1,0, 1,32'd2)); // old value
    vq.push_back(mk(0,1,3'd3,32'd0,4'h1, 4'h1,0, 1,32'd7));

    // Reset state
    rst_n = 0; sig_in = 4'b1010; cfg_we = 0; cfg_re = 0; cfg_addr = 0; cfg_wdata = 0;
    ncyc = 0; model_reset();
    #2;
    chk("reset_sig_out", 32'(sig_out), 32'h0000_000A);
    chk("reset_rdata", cfg_rdata, 32'd0);
    chk("reset_active", 32'(patch_active), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    sig_cur = 4'b1010;
    rd(3'd7);
    chk("reset_status", cfg_rdata, 32'd0);

    // Table vectors
    foreach (vq[k]) begin
      sig_cur = vq[k].sig;
      cycle(vq[k].we, vq[k].re, vq[k].addr, vq[k].wdata, vq[k].sig);
      chk($sformatf("vec%0d_sig_out", k), 32'(sig_out), 32'(vq[k].exp_out));
      chk($sformatf("vec%0d_active", k), 32'(patch_active), 32'(vq[k].exp_act));
      if (vq[k].chk_rd) chk($sformatf("vec%0d_rdata", k), cfg_rdata, vq[k].exp_rd);
    end

    // HOLD on ch2, INVERT on ch3, open-ended window, then DISARM
    wr(3'd5, 2); wr(3'd6, 4); wr(3'd5, 3); wr(3'd6, 3);
    wr(3'd3, 0); wr(3'd4, 0); wr(3'd1, 4'b0100); wr(3'd2, 4'b0100);
    sig_cur = 4'b0100; wr(3'd0, 1);
    idle(1);
    sig_cur = 4'b0000; idle(1);
    chk("hold_ch2", 32'(sig_out[2]), 32'd1);
    chk("invert_ch3", 32'(sig_out[3]), 32'd1);
    sig_cur = 4'b1000; idle(3);
    chk("hold_ch2_late", 32'(sig_out[2]), 32'd1);
    chk("invert_ch3_late", 32'(sig_out[3]), 32'd0);
    wr(3'd0, 2);
    chk("disarm_release", 32'(sig_out), 32'(sig_cur));
    chk("disarm_inactive", 32'(patch_active), 32'd0);

    // DISARM during DELAY: no window, count unchanged
    wr(3'd3, 5); wr(3'd4, 2); wr(3'd1, 0); wr(3'd0, 1);
    idle(3);
    wr(3'd0, 2);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("disarm_delay_noactive", 32'(patch_active), 32'd0);
    end
    rd(3'd7);
    chk("disarm_delay_status", cfg_rdata, 32'h0000_0200);

    // REARM with DURATION 1 and an empty mask: count saturates
    wr(3'd3, 0); wr(3'd4, 1); wr(3'd0, 5);
    idle(520);
    wr(3'd0, 2);
    rd(3'd7);
    chk("saturate_status", cfg_rdata, 32'h0000_FF00);

    // Asynchronous reset in the middle of a FORCE0 window
    wr(3'd5, 0); wr(3'd6, 1); wr(3'd4, 0); wr(3'd3, 0); wr(3'd1, 0);
    sig_cur = 4'b0001; wr(3'd0, 1);
    idle(1);
    chk("force0_ch0", 32'(sig_out[0]), 32'd0);
    rst_n = 0; #1;
    chk("midreset_sig_out", 32'(sig_out), 32'h1);
    chk("midreset_active", 32'(patch_active), 32'd0);
    chk("midreset_rdata", cfg_rdata, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1;
    rd(3'd6);
    chk("postreset_mode0", cfg_rdata, 32'd0);
    wr(3'd5, 1); rd(3'd6);
    chk("postreset_mode1", cfg_rdata, 32'd0);
    rd(3'd7);
    chk("postreset_status", cfg_rdata, 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      we_r = ($urandom % 3) == 0;
      re_r = ($urandom % 3) == 0;
      a_r  = 3'($urandom % 8);
      d_r  = $urandom;
      if (a_r == 3'd3 || a_r == 3'd4) d_r = $urandom_range(0, 4);
      if (a_r == 3'd0)
        case ($urandom % 6)
          0, 1:    d_r = 32'd1;
          2:       d_r = 32'd5;
          3:       d_r = 32'd2;
          4:       d_r = 32'd4;
          default: d_r = 32'd0;
        endcase
      sig_cur = 4'($urandom);
      cycle(we_r, re_r, a_r, d_r, sig_cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
